muldiv_unit: RTL and testbench
==============================

// Module: muldiv_unit
// PURPOSE
//  Iterative multiply/divide unit with architectural HI/LO registers. Generalises the execute-stage ALU
//  to multi-cycle MULT/MULTU/DIV/DIVU, with start/busy/done handshake, pipeline-flush cancel and MTHI/MTLO writes.
//  Sits beside the ALU in EX; the hazard unit stalls the pipeline while busy_o is high.
// PARAMETERS
//  WIDTH     32  operand width; products/quotient+remainder are 2*WIDTH bits split across HI/LO
//  FAST_MUL  0   1: multiply completes in one cycle (single-cycle product); 0: shift-add, WIDTH iterations
// PORTS
//  clk        in   1        clock, all state on rising edge
//  resetn     in   1        asynchronous, active-low reset
//  start_i    in   1        start request, sampled only in IDLE
//  op_i       in   2        00 MULTU, 01 MULT (signed), 10 DIVU, 11 DIV (signed); sampled with start_i
//  a_i        in   WIDTH    multiplicand / dividend, sampled with start_i
//  b_i        in   WIDTH    multiplier / divisor, sampled with start_i
//  cancel_i   in   1        flush: abort current operation, no HI/LO update
//  hi_we_i    in   1        MTHI write enable
//  lo_we_i    in   1        MTLO write enable
//  hi_wdata_i in   WIDTH    MTHI data
//  lo_wdata_i in   WIDTH    MTLO data
//  busy_o     out  1        state != IDLE
//  done_o     out  1        one-cycle pulse, state == FIN
//  res_hi_o   out  WIDTH    result high half (product high / remainder), valid while done_o
//  res_lo_o   out  WIDTH    result low half (product low / quotient), valid while done_o
//  hi_o       out  WIDTH    architectural HI register
//  lo_o       out  WIDTH    architectural LO register
// BEHAVIOUR
//  Reset: state IDLE, busy_o=0, done_o=0, hi_o=lo_o=0, res_hi_o=res_lo_o=0, iteration counter=0.
//  FSM IDLE -> CALC -> FIN -> IDLE.
//   IDLE: start_i=1 & cancel_i=0 -> latch op/operands, counter=0, go CALC (FAST_MUL=1 & multiply: go FIN,
//         result computed from a_i,b_i at that edge).
//   CALC: one radix-2 iteration per cycle (shift-add multiply or restoring divide on magnitudes);
//         counter==WIDTH-1 -> apply signs, load res_hi/res_lo, go FIN.
//   FIN:  done_o=1 for exactly one cycle; at leaving edge HI<=res_hi, LO<=res_lo; always go IDLE.
//  Latency: start in cycle 0 -> done_o in cycle WIDTH+1 (cycle 1 for FAST_MUL multiply); HI/LO new from cycle after done.
//  start_i outside IDLE ignored; op/operand inputs ignored outside start cycle.
//  Signed ops: operate on magnitudes, WIDTH-bit two's complement. Product negated if signs differ.
//   Quotient truncates toward zero; remainder takes sign of dividend.
//   Most-negative / -1: quotient = 1<<(WIDTH-1), remainder 0 (no trap).
//  Divide by zero (signed or unsigned): LO = all ones, HI = dividend; full latency still applies.
//  cancel_i: in any state -> IDLE at next edge, no done_o, HI/LO unchanged (including in FIN: commit suppressed).
//   cancel_i with start_i in IDLE: start ignored.
//  hi_we_i/lo_we_i: take effect at the edge only in IDLE; ignored when busy_o=1. Same-cycle start and
//   write in IDLE: both act; the later commit of the operation overwrites HI/LO.
//  resetn low mid-operation: immediate return to reset values, operation discarded.
// TESTING
//  MULTU a=7 b=6 -> done_o exactly cycle 33, res_hi=0 res_lo=42; hi_o=0 lo_o=0x2A from cycle 34; busy_o cycles 1..33.
//  MULT a=0xFFFFFFFD(-3) b=5 -> hi_o=0xFFFFFFFF lo_o=0xFFFFFFF1; MULTU 0xFFFFFFFF^2 -> hi=0xFFFFFFFE lo=0x00000001.
//  DIV -7/2 -> lo_o=0xFFFFFFFD hi_o=0xFFFFFFFF; DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000 hi=0; DIVU 100/7 -> lo=14 hi=2.
//  DIVU 10/0 -> lo_o=0xFFFFFFFF hi_o=0x0000000A after cycle 33.
//  MTHI 0x1234 then DIV 9/4 with cancel_i at cycle 10 -> no done_o, busy_o low cycle 11, hi_o=0x1234;
//   MTLO while busy ignored; resetn low at cycle 5 -> all outputs zero immediately.
//  FAST_MUL=1: MULT 0xFFFF8000*2 -> done_o cycle 1, lo=0xFFFF0000 hi=0xFFFFFFFF; DIVU still done at cycle 33.

Source files
------------

// File: rtl/muldiv_unit_if.sv
// Request/response bundle between the execute stage and the iterative multiply/divide unit.
interface muldiv_unit_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start_i;
  logic [1:0]       op_i;
  logic [WIDTH-1:0] a_i;
  logic [WIDTH-1:0] b_i;
  logic             cancel_i;
  logic             hi_we_i;
  logic             lo_we_i;
  logic [WIDTH-1:0] hi_wdata_i;
  logic [WIDTH-1:0] lo_wdata_i;
  logic             busy_o;
  logic             done_o;
  logic [WIDTH-1:0] res_hi_o;
  logic [WIDTH-1:0] res_lo_o;
  logic [WIDTH-1:0] hi_o;
  logic [WIDTH-1:0] lo_o;

  modport master (
    output start_i, op_i, a_i, b_i, cancel_i, hi_we_i, lo_we_i, hi_wdata_i, lo_wdata_i,
    input  busy_o, done_o, res_hi_o, res_lo_o, hi_o, lo_o
  );

  modport slave (
    input  start_i, op_i, a_i, b_i, cancel_i, hi_we_i, lo_we_i, hi_wdata_i, lo_wdata_i,
    output busy_o, done_o, res_hi_o, res_lo_o, hi_o, lo_o
  );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with architectural HI/LO, cancel on flush and MTHI/MTLO writes.
module muldiv_unit #(
  parameter int unsigned WIDTH    = 32,
  parameter bit          FAST_MUL = 1'b0
) (
  input logic          clk,
  input logic          resetn,
  muldiv_unit_if.slave bus
);
  localparam int unsigned W2 = 2 * WIDTH;
  localparam int unsigned CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             is_div_q, is_div_d;
  logic             neg_a_q, neg_a_d;
  logic             neg_b_q, neg_b_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] m_q, m_d;
  logic [W2-1:0]    p_q, p_d;
  logic [WIDTH-1:0] res_hi_q, res_hi_d;
  logic [WIDTH-1:0] res_lo_q, res_lo_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             busy_q, done_q;

  logic             a_neg_in, b_neg_in;
  logic [WIDTH-1:0] a_mag_in, b_mag_in;
  logic [W2-1:0]    fast_prod;

  // Operand magnitudes and sign flags at the start edge
  always_comb begin
    a_neg_in  = bus.op_i[0] & bus.a_i[WIDTH-1];
    b_neg_in  = bus.op_i[0] & bus.b_i[WIDTH-1];
    a_mag_in  = a_neg_in ? -bus.a_i : bus.a_i;
    b_mag_in  = b_neg_in ? -bus.b_i : bus.b_i;
    fast_prod = W2'(a_mag_in) * W2'(b_mag_in);
    if (a_neg_in ^ b_neg_in) fast_prod = -fast_prod;
  end

  logic [WIDTH:0]   mul_sum, mul_up, div_sh;
  logic [WIDTH-1:0] div_rem;
  logic             div_ge;
  logic [W2-1:0]    p_step, prod_s;
  logic [WIDTH-1:0] quo_s, rem_s;

  // One radix-2 step: p holds {acc, multiplier} for multiply, {remainder, quotient} for divide
  always_comb begin
    mul_sum = {1'b0, p_q[W2-1:WIDTH]} + {1'b0, m_q};
    mul_up  = p_q[0] ? mul_sum : {1'b0, p_q[W2-1:WIDTH]};
    div_sh  = {p_q[W2-1:WIDTH], p_q[WIDTH-1]};
    div_ge  = div_sh >= {1'b0, m_q};
    div_rem = div_ge ? WIDTH'(div_sh - {1'b0, m_q}) : WIDTH'(div_sh);
    if (is_div_q) p_step = {div_rem, p_q[WIDTH-2:0], div_ge};
    else          p_step = {mul_up, p_q[WIDTH-1:1]};
    prod_s = (neg_a_q ^ neg_b_q) ? -p_step : p_step;
    quo_s  = (neg_a_q ^ neg_b_q) ? -p_step[WIDTH-1:0] : p_step[WIDTH-1:0];
    rem_s  = neg_a_q ? -p_step[W2-1:WIDTH] : p_step[W2-1:WIDTH];
  end

  // Next-state and datapath control
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    is_div_d = is_div_q;
    neg_a_d  = neg_a_q;
    neg_b_d  = neg_b_q;
    a_d      = a_q;
    m_d      = m_q;
    p_d      = p_q;
    res_hi_d = res_hi_q;
    res_lo_d = res_lo_q;
    hi_d     = hi_q;
    lo_d     = lo_q;

    unique case (state_q)
      IDLE: begin
        if (bus.hi_we_i) hi_d = bus.hi_wdata_i;
        if (bus.lo_we_i) lo_d = bus.lo_wdata_i;
        if (bus.start_i && !bus.cancel_i) begin
          is_div_d = bus.op_i[1];
          neg_a_d  = a_neg_in;
          neg_b_d  = b_neg_in;
          a_d      = bus.a_i;
          cnt_d    = '0;
          m_d      = bus.op_i[1] ? b_mag_in : a_mag_in;
          p_d      = {{WIDTH{1'b0}}, (bus.op_i[1] ? a_mag_in : b_mag_in)};
          if (FAST_MUL && !bus.op_i[1]) begin
            res_hi_d = fast_prod[W2-1:WIDTH];
            res_lo_d = fast_prod[WIDTH-1:0];
            state_d  = FIN;
          end else begin
            state_d  = CALC;
          end
        end
      end
      CALC: begin
        p_d   = p_step;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = FIN;
          if (!is_div_q) begin
            res_hi_d = prod_s[W2-1:WIDTH];
            res_lo_d = prod_s[WIDTH-1:0];
          end else if (m_q == '0) begin
            res_hi_d = a_q;
            res_lo_d = '1;
          end else begin
            res_hi_d = rem_s;
            res_lo_d = quo_s;
          end
        end
      end
      FIN: begin
        state_d = IDLE;
        hi_d    = res_hi_q;
        lo_d    = res_lo_q;
      end
      default: state_d = IDLE;
    endcase

    // Flush wins over everything except MTHI/MTLO in IDLE; a cancelled FIN never commits
    if (bus.cancel_i) begin
      state_d = IDLE;
      if (state_q == FIN) begin
        hi_d = hi_q;
        lo_d = lo_q;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      is_div_q <= 1'b0;
      neg_a_q  <= 1'b0;
      neg_b_q  <= 1'b0;
      a_q      <= '0;
      m_q      <= '0;
      p_q      <= '0;
      res_hi_q <= '0;
      res_lo_q <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      is_div_q <= is_div_d;
      neg_a_q  <= neg_a_d;
      neg_b_q  <= neg_b_d;
      a_q      <= a_d;
      m_q      <= m_d;
      p_q      <= p_d;
      res_hi_q <= res_hi_d;
      res_lo_q <= res_lo_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      busy_q   <= (state_d != IDLE);
      done_q   <= (state_d == FIN);
    end
  end

  assign bus.busy_o   = busy_q;
  assign bus.done_o   = done_q;
  assign bus.res_hi_o = res_hi_q;
  assign bus.res_lo_o = res_lo_q;
  assign bus.hi_o     = hi_q;
  assign bus.lo_o     = lo_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// Directed + scoreboard bench for muldiv_unit, iterative and single-cycle-multiply builds side by side.
module tb_muldiv_unit;
  localparam int unsigned W = 32;

  logic        clk;
  logic        resetn;
  int          checks;
  int          errors;
  logic [63:0] sb_q[$];

  muldiv_unit_if #(.WIDTH(W)) bs ();
  muldiv_unit_if #(.WIDTH(W)) bf ();

  muldiv_unit #(.WIDTH(W), .FAST_MUL(1'b0)) dut (.clk(clk), .resetn(resetn), .bus(bs.slave));
  muldiv_unit #(.WIDTH(W), .FAST_MUL(1'b1)) dut_fast (.clk(clk), .resetn(resetn), .bus(bf.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Reference {HI, LO} from 64-bit arithmetic
  function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    logic [63:0] r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      2'd0: r = {32'b0, a} * {32'b0, b};
      2'd1: r = 64'(sa * sb);
      2'd2: r = (b == 32'd0) ? {a, 32'hFFFF_FFFF} : {a % b, a / b};
      default: r = (b == 32'd0) ? {a, 32'hFFFF_FFFF} : {32'(sa % sb), 32'(sa / sb)};
    endcase
    return r;
  endfunction

  task automatic clear_inputs();
    bs.start_i = 1'b0; bs.op_i = 2'd0; bs.a_i = '0; bs.b_i = '0; bs.cancel_i = 1'b0;
    bs.hi_we_i = 1'b0; bs.lo_we_i = 1'b0; bs.hi_wdata_i = '0; bs.lo_wdata_i = '0;
    bf.start_i = 1'b0; bf.op_i = 2'd0; bf.a_i = '0; bf.b_i = '0; bf.cancel_i = 1'b0;
    bf.hi_we_i = 1'b0; bf.lo_we_i = 1'b0; bf.hi_wdata_i = '0; bf.lo_wdata_i = '0;
  endtask

  // Called at a negedge (cycle 0); returns at the negedge of the cycle after done
  task automatic run_op(input bit fast, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int exp_lat, input string tag);
    int          lat;
    int          busy_cnt;
    bit          seen;
    logic [63:0] e;
    logic [63:0] res;
    if (fast) begin bf.start_i = 1'b1; bf.op_i = op; bf.a_i = a; bf.b_i = b; end
    else      begin bs.start_i = 1'b1; bs.op_i = op; bs.a_i = a; bs.b_i = b; end
    sb_q.push_back(model(op, a, b));
    @(negedge clk);
    bs.start_i = 1'b0; bf.start_i = 1'b0; bs.hi_we_i = 1'b0; bs.lo_we_i = 1'b0;
    bs.op_i = ~op; bs.a_i = $urandom; bs.b_i = $urandom;
    bf.op_i = ~op; bf.a_i = $urandom; bf.b_i = $urandom;
    lat = 1; busy_cnt = 0; seen = 1'b0; res = '0;
    while (!seen && lat < 80) begin
      if (fast ? bf.busy_o : bs.busy_o) busy_cnt++;
      if (fast ? bf.done_o : bs.done_o) begin
        seen = 1'b1;
        res  = fast ? {bf.res_hi_o, bf.res_lo_o} : {bs.res_hi_o, bs.res_lo_o};
      end else begin
        @(negedge clk);
        lat++;
      end
    end
    e = sb_q.pop_front();
    chk({tag, " latency"}, 64'(lat), 64'(exp_lat));
    chk({tag, " busy cycles"}, 64'(busy_cnt), 64'(exp_lat));
    if (seen) chk({tag, " result"}, res, e);
    @(negedge clk);
    chk({tag, " hi/lo"}, fast ? {bf.hi_o, bf.lo_o} : {bs.hi_o, bs.lo_o}, e);
    chk({tag, " idle after"}, {63'b0, (fast ? bf.busy_o : bs.busy_o)}, 64'd0);
  endtask

  initial begin
    int dones;
    checks = 0;
    errors = 0;
    clear_inputs();
    resetn = 1'b0;
    #12;
    chk("reset busy/done", {62'b0, bs.busy_o, bs.done_o}, 64'd0);
    chk("reset hi/lo", {bs.hi_o, bs.lo_o}, 64'd0);
    chk("reset res", {bs.res_hi_o, bs.res_lo_o}, 64'd0);
    chk("reset fast hi/lo", {bf.hi_o, bf.lo_o}, 64'd0);
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);

    run_op(1'b0, 2'd0, 32'd7, 32'd6, 33, "multu 7x6");
    run_op(1'b0, 2'd1, 32'hFFFF_FFFD, 32'd5, 33, "mult -3x5");
    run_op(1'b0, 2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33, "multu max^2");
    run_op(1'b0, 2'd1, 32'h8000_0000, 32'h8000_0000, 33, "mult minneg^2");
    run_op(1'b0, 2'd3, 32'hFFFF_FFF9, 32'd2, 33, "div -7/2");
    run_op(1'b0, 2'd3, 32'h8000_0000, 32'hFFFF_FFFF, 33, "div minneg/-1");
    run_op(1'b0, 2'd3, 32'd7, 32'hFFFF_FFFE, 33, "div 7/-2");
    run_op(1'b0, 2'd2, 32'd100, 32'd7, 33, "divu 100/7");
    run_op(1'b0, 2'd2, 32'd10, 32'd0, 33, "divu 10/0");
    run_op(1'b0, 2'd3, 32'hFFFF_FFF6, 32'd0, 33, "div -10/0");
    run_op(1'b0, 2'd2, 32'hFFFF_FFFF, 32'd1, 33, "divu max/1");
    for (int i = 0; i < 4; i++) begin
      logic [1:0] rop;
      rop = 2'($urandom_range(0, 3));
      run_op(1'b0, rop, $urandom, $urandom_range(1, 32'hFFFF), 33, "random op");
    end

    run_op(1'b1, 2'd1, 32'hFFFF_8000, 32'd2, 1, "fast mult");
    run_op(1'b1, 2'd0, 32'hDEAD_BEEF, 32'h1234_5678, 1, "fast multu");
    run_op(1'b1, 2'd2, 32'd100, 32'd7, 33, "fast divu");

    // MTHI/MTLO, then a divide flushed at cycle 10 with an MTLO attempted while busy
    bs.hi_we_i = 1'b1; bs.hi_wdata_i = 32'h1234;
    bs.lo_we_i = 1'b1; bs.lo_wdata_i = 32'h5678;
    @(negedge clk);
    bs.hi_we_i = 1'b0; bs.lo_we_i = 1'b0;
    chk("mthi/mtlo", {bs.hi_o, bs.lo_o}, {32'h1234, 32'h5678});
    bs.start_i = 1'b1; bs.op_i = 2'd3; bs.a_i = 32'd9; bs.b_i = 32'd4;
    @(negedge clk);
    bs.start_i = 1'b0;
    repeat (4) @(negedge clk);
    bs.lo_we_i = 1'b1; bs.lo_wdata_i = 32'hBEEF;
    @(negedge clk);
    bs.lo_we_i = 1'b0;
    repeat (4) @(negedge clk);
    bs.cancel_i = 1'b1;
    @(negedge clk);
    bs.cancel_i = 1'b0;
    chk("cancel busy low", {63'b0, bs.busy_o}, 64'd0);
    dones = 0;
    repeat (40) begin
      if (bs.done_o) dones++;
      @(negedge clk);
    end
    chk("cancel no done", 64'(dones), 64'd0);
    chk("cancel hi/lo kept", {bs.hi_o, bs.lo_o}, {32'h1234, 32'h5678});

    // Start together with cancel in IDLE is dropped
    bs.start_i = 1'b1; bs.cancel_i = 1'b1; bs.op_i = 2'd0; bs.a_i = 32'd3; bs.b_i = 32'd3;
    @(negedge clk);
    bs.start_i = 1'b0; bs.cancel_i = 1'b0;
    chk("start+cancel busy", {63'b0, bs.busy_o}, 64'd0);
    @(negedge clk);
    chk("start+cancel idle", {62'b0, bs.busy_o, bs.done_o}, 64'd0);

    // Cancel during FIN suppresses the commit
    bs.start_i = 1'b1; bs.op_i = 2'd0; bs.a_i = 32'd3; bs.b_i = 32'd3;
    @(negedge clk);
    bs.start_i = 1'b0;
    repeat (32) @(negedge clk);
    chk("fin done pulse", {63'b0, bs.done_o}, 64'd1);
    bs.cancel_i = 1'b1;
    @(negedge clk);
    bs.cancel_i = 1'b0;
    chk("fin cancel hi/lo", {bs.hi_o, bs.lo_o}, {32'h1234, 32'h5678});
    chk("fin cancel idle", {62'b0, bs.busy_o, bs.done_o}, 64'd0);

    // Same-cycle MTHI and start: the write lands, then the commit overwrites it
    bs.hi_we_i = 1'b1; bs.hi_wdata_i = 32'hAAAA_AAAA;
    run_op(1'b0, 2'd0, 32'd3, 32'd4, 33, "start+mthi");

    // Asynchronous reset mid-operation
    bs.start_i = 1'b1; bs.op_i = 2'd1; bs.a_i = 32'd5; bs.b_i = 32'd5;
    @(negedge clk);
    bs.start_i = 1'b0;
    repeat (4) @(negedge clk);
    resetn = 1'b0;
    #1;
    chk("midop reset busy/done", {62'b0, bs.busy_o, bs.done_o}, 64'd0);
    chk("midop reset hi/lo", {bs.hi_o, bs.lo_o}, 64'd0);
    chk("midop reset res", {bs.res_hi_o, bs.res_lo_o}, 64'd0);
    chk("midop reset fast hi/lo", {bf.hi_o, bf.lo_o}, 64'd0);
    @(negedge clk);
    resetn = 1'b1;
    repeat (3) @(negedge clk);
    chk("post reset idle", {62'b0, bs.busy_o, bs.done_o}, 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
